screen_mux_sync: RTL and testbench

- Registered, parametrised N-way VGA screen-source selector. It replaces the combinational title/game/highscore mux between the screen generators and the VGA output stage.
- Source changes take effect only at a frame boundary: the rising edge of vsync on the bus currently driving timing.
- After a change, the block can insert a programmable number of blanked frames, with RGB forced to 0 and timing kept intact, so no torn or partial frames reach the monitor.

---
 rtl/screen_mux_sync.sv | 128 ++++++++++++
 tb/tb_screen_mux_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/screen_mux_sync.sv
// Registered N-way VGA source selector. Source changes commit only at a vsync
// rising edge of the timing source, optionally followed by RGB-blanked frames.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 16
`endif

module screen_mux_sync #(
  parameter int N_SRC        = 4,
  parameter int SEL_W        = 2,
  parameter int BUS_W        = `VGA_BUS_SIZE,
  parameter int VSYNC_BIT    = 0,
  parameter int RGB_LSB      = 0,
  parameter int RGB_W        = 12,
  parameter int BLANK_FRAMES = 2,
  parameter int DEFAULT_SRC  = 0
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [N_SRC*BUS_W-1:0] vga_in,
  input  logic [N_SRC-1:0]       sel_vec,
  output logic [BUS_W-1:0]       vga_out,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   switching
);

  localparam logic [1:0] SHOW    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] BLANK   = 2'd2;

  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_SRC);
  localparam logic [3:0]       BLANK_N  = 4'(BLANK_FRAMES);
  localparam logic [BUS_W-1:0] RGB_MASK = BUS_W'((64'd1 << RGB_W) - 64'd1) << RGB_LSB;

  // Handshake: none; sel_vec is a level sampled every pclk, vga_out is valid every cycle.

  logic [BUS_W-1:0] src [N_SRC];
  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign src[g] = vga_in[g*BUS_W +: BUS_W];
  end

  logic [1:0]       state, state_n;
  logic [SEL_W-1:0] target, target_n, active_n;
  logic [SEL_W-1:0] req, tsrc, tsrc_n;
  logic [3:0]       count, count_n;
  logic             vsync_prev;
  logic             frame_start;

  // Lowest set index wins; an empty vector falls back to the default source.
  always_comb begin
    req = DEF_SEL;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (sel_vec[i]) req = SEL_W'(i);
    end
  end

  assign tsrc        = (state == BLANK) ? target : active_sel;
  assign frame_start = src[tsrc][VSYNC_BIT] & ~vsync_prev;

  always_comb begin
    state_n  = state;
    active_n = active_sel;
    target_n = target;
    count_n  = count;
    case (state)
      SHOW: begin
        if (req != active_sel) begin
          target_n = req;
          state_n  = PENDING;
        end
      end
      PENDING: begin
        // A frame boundary wins over a same-cycle request change.
        if (frame_start) begin
          if (BLANK_FRAMES == 0) begin
            active_n = target;
            state_n  = SHOW;
          end else begin
            count_n = BLANK_N;
            state_n = BLANK;
          end
        end else if (req == active_sel) begin
          state_n = SHOW;
        end else begin
          target_n = req;
        end
      end
      BLANK: begin
        if (frame_start) begin
          if (count <= 4'd1) begin
            count_n  = 4'd0;
            active_n = target;
            state_n  = SHOW;
          end else begin
            count_n = 4'(count - 4'd1);
          end
        end else if (req != target) begin
          target_n = req;
          count_n  = BLANK_N;
        end
      end
      default: state_n = SHOW;
    endcase
    tsrc_n = (state_n == BLANK) ? target_n : active_n;
  end

  // vsync_prev follows whichever source will drive timing next cycle, so a
  // timing-source change never manufactures a false vsync edge.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= SHOW;
      active_sel <= DEF_SEL;
      target     <= DEF_SEL;
      count      <= 4'd0;
      vsync_prev <= 1'b0;
      vga_out    <= '0;
      switching  <= 1'b0;
    end else begin
      state      <= state_n;
      active_sel <= active_n;
      target     <= target_n;
      count      <= count_n;
      vsync_prev <= src[tsrc_n][VSYNC_BIT];
      vga_out    <= (state == BLANK) ? (src[target] & ~RGB_MASK) : src[active_sel];
      switching  <= (state_n != SHOW);
    end
  end

endmodule

// File: tb/tb_screen_mux_sync.sv
// Directed bench for screen_mux_sync: one instance with 2 blank frames and one
// with none, sharing the source buses but with independent select vectors.
module tb_screen_mux_sync;

  localparam logic [15:0] RGB_MASK = 16'hFFF0;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [63:0] vga_in = '0;
  logic [3:0]  sel_vec = 4'b0001;
  logic [3:0]  sel0    = 4'b0001;
  logic [15:0] vga_out, vga_out0;
  logic [1:0]  active_sel, active_sel0;
  logic        switching, switching0;
  logic [7:0]  stamp = 8'd0;

  int tests = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  screen_mux_sync #(.N_SRC(4), .SEL_W(2), .BUS_W(16), .VSYNC_BIT(0), .RGB_LSB(4),
                    .RGB_W(12), .BLANK_FRAMES(2), .DEFAULT_SRC(0)) dut (
    .pclk(pclk), .rst(rst), .vga_in(vga_in), .sel_vec(sel_vec),
    .vga_out(vga_out), .active_sel(active_sel), .switching(switching));

  screen_mux_sync #(.N_SRC(4), .SEL_W(2), .BUS_W(16), .VSYNC_BIT(0), .RGB_LSB(4),
                    .RGB_W(12), .BLANK_FRAMES(0), .DEFAULT_SRC(0)) dut0 (
    .pclk(pclk), .rst(rst), .vga_in(vga_in), .sel_vec(sel0),
    .vga_out(vga_out0), .active_sel(active_sel0), .switching(switching0));

  typedef struct {
    logic [3:0] sel;
    logic [3:0] vs;
    int         a;
    bit         sw;
    int         src;
    bit         bl;
  } vec_t;

  vec_t tbl[30];

  // Bus layout: [15:12]=src+1, [11:4]=stamp (RGB = [15:4]), [3:1]=src, [0]=vsync.
  function automatic logic [15:0] mk_bus(input int i, input logic [3:0] v, input logic [7:0] st);
    return {4'(i + 1), st, 3'(i), v[i]};
  endfunction

  task automatic drive(input logic [3:0] v);
    for (int i = 0; i < 4; i++) vga_in[i*16 +: 16] = mk_bus(i, v, stamp);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic [3:0] s0, input logic [3:0] v,
                      input bit use0, input int ea, input bit esw, input int esrc,
                      input bit ebl, input string tag);
    logic [15:0] exp_bus;
    @(negedge pclk);
    sel_vec = s;
    sel0    = s0;
    stamp   = stamp + 8'd1;
    drive(v);
    @(posedge pclk);
    #1;
    exp_bus = mk_bus(esrc, v, stamp);
    if (ebl) exp_bus = exp_bus & ~RGB_MASK;
    if (use0) begin
      chk({tag, "_out"}, 32'(vga_out0), 32'(exp_bus));
      chk({tag, "_act"}, 32'(active_sel0), 32'(ea));
      chk({tag, "_sw"},  32'(switching0), 32'(esw));
    end else begin
      chk({tag, "_out"}, 32'(vga_out), 32'(exp_bus));
      chk({tag, "_act"}, 32'(active_sel), 32'(ea));
      chk({tag, "_sw"},  32'(switching), 32'(esw));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // sel, vs, active, switching, out_src, blanked  (dut, BLANK_FRAMES=2)
    tbl[0]  = '{4'b0001, 4'b0000, 0, 0, 0, 0};
    tbl[1]  = '{4'b0000, 4'b0001, 0, 0, 0, 0};  // empty select -> default
    tbl[2]  = '{4'b0001, 4'b0000, 0, 0, 0, 0};
    tbl[3]  = '{4'b0010, 4'b0000, 0, 1, 0, 0};  // request src1
    tbl[4]  = '{4'b0010, 4'b0010, 0, 1, 0, 0};  // src1 vsync is not timing
    tbl[5]  = '{4'b0010, 4'b0011, 0, 1, 0, 0};  // src0 rise -> BLANK
    tbl[6]  = '{4'b0010, 4'b0010, 0, 1, 1, 1};  // src1 already high: no edge
    tbl[7]  = '{4'b0010, 4'b0000, 0, 1, 1, 1};
    tbl[8]  = '{4'b0010, 4'b0010, 0, 1, 1, 1};  // count 2->1
    tbl[9]  = '{4'b0010, 4'b0000, 0, 1, 1, 1};
    tbl[10] = '{4'b0010, 4'b0010, 1, 0, 1, 1};  // commit
    tbl[11] = '{4'b0010, 4'b0000, 1, 0, 1, 0};
    tbl[12] = '{4'b0001, 4'b0000, 1, 1, 1, 0};  // request src0
    tbl[13] = '{4'b0010, 4'b0000, 1, 0, 1, 0};  // cancel
    tbl[14] = '{4'b1010, 4'b0000, 1, 0, 1, 0};  // priority -> 1
    tbl[15] = '{4'b0100, 4'b0000, 1, 1, 1, 0};
    tbl[16] = '{4'b0100, 4'b0010, 1, 1, 1, 0};  // src1 rise -> BLANK on src2
    tbl[17] = '{4'b0100, 4'b0100, 1, 1, 2, 1};  // count 2->1
    tbl[18] = '{4'b1000, 4'b0000, 1, 1, 2, 1};  // retarget to 3, reload
    tbl[19] = '{4'b1000, 4'b1000, 1, 1, 3, 1};  // count 2->1
    tbl[20] = '{4'b1000, 4'b0000, 1, 1, 3, 1};
    tbl[21] = '{4'b1000, 4'b1000, 3, 0, 3, 1};  // commit src3
    tbl[22] = '{4'b1000, 4'b0000, 3, 0, 3, 0};
    tbl[23] = '{4'b0001, 4'b0000, 3, 1, 3, 0};
    tbl[24] = '{4'b0010, 4'b1000, 3, 1, 3, 0};  // edge + req change: old target kept
    tbl[25] = '{4'b0010, 4'b0000, 3, 1, 0, 1};  // BLANK on src0, then retarget 1
    tbl[26] = '{4'b0010, 4'b0010, 3, 1, 1, 1};
    tbl[27] = '{4'b0010, 4'b0000, 3, 1, 1, 1};
    tbl[28] = '{4'b0010, 4'b0010, 1, 0, 1, 1};
    tbl[29] = '{4'b0010, 4'b0000, 1, 0, 1, 0};

    // Reset state
    drive(4'b0000);
    @(negedge pclk);
    chk("rst_out", 32'(vga_out), 32'h0);
    chk("rst_act", 32'(active_sel), 32'h0);
    chk("rst_sw",  32'(switching), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 30; k++)
      step(tbl[k].sel, 4'b0001, tbl[k].vs, 1'b0, tbl[k].a, tbl[k].sw, tbl[k].src,
           tbl[k].bl, $sformatf("vec%0d", k));

    // BLANK_FRAMES=0: immediate commit at src0 rise, then edge+req-change case.
    step(4'b0100, 4'b0010, 4'b0000, 1'b1, 0, 1, 0, 0, "z_req");
    step(4'b0100, 4'b0010, 4'b0010, 1'b1, 0, 1, 0, 0, "z_wait");
    step(4'b0100, 4'b0010, 4'b0001, 1'b1, 1, 0, 0, 0, "z_commit");
    step(4'b0100, 4'b0010, 4'b0000, 1'b1, 1, 0, 1, 0, "z_show");
    step(4'b0100, 4'b0100, 4'b0000, 1'b1, 1, 1, 1, 0, "z_req2");
    step(4'b0100, 4'b1000, 4'b0010, 1'b1, 2, 0, 1, 0, "z_old_tgt");
    step(4'b0100, 4'b1000, 4'b0000, 1'b1, 2, 1, 2, 0, "z_fresh");

    // Asynchronous reset mid-switch, between clock edges
    @(negedge pclk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out",  32'(vga_out),     32'h0);
    chk("arst_act",  32'(active_sel),  32'h0);
    chk("arst_sw",   32'(switching),   32'h0);
    chk("arst_out0", 32'(vga_out0),    32'h0);
    chk("arst_act0", 32'(active_sel0), 32'h0);
    chk("arst_sw0",  32'(switching0),  32'h0);
    @(negedge pclk);
    sel_vec = 4'b0100;
    sel0    = 4'b0001;
    drive(4'b0000);
    @(negedge pclk);
    rst = 1'b0;

    step(4'b0100, 4'b0001, 4'b0000, 1'b0, 0, 1, 0, 0, "r_req");
    step(4'b0100, 4'b0001, 4'b0001, 1'b0, 0, 1, 0, 0, "r_edge");
    step(4'b0100, 4'b0001, 4'b0100, 1'b0, 0, 1, 2, 1, "r_blank1");
    step(4'b0100, 4'b0001, 4'b0000, 1'b0, 0, 1, 2, 1, "r_blank2");
    step(4'b0100, 4'b0001, 4'b0100, 1'b0, 2, 0, 2, 1, "r_commit");
    step(4'b0100, 4'b0001, 4'b0000, 1'b0, 2, 0, 2, 0, "r_show");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
